// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash responder and its bench peers.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [1:0] MODE_CONT     = 2'b10;

endpackage

// File: rtl/qspi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus SCK rise/fall pulse generation
// on the system clock.
module qspi_pin_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_select,
    input  logic       i_sck,
    input  logic [3:0] i_data,
    output logic       o_select,
    output logic       o_sck_rise,
    output logic       o_sck_fall,
    output logic [3:0] o_data
);

    logic       r_sel_meta, r_sel_sync;
    logic       r_sck_meta, r_sck_sync, r_sck_prev;
    logic [3:0] r_data_meta, r_data_sync;

    // NOTE: select resets to its deasserted level so a reset never looks like
    // the start of a transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_meta  <= 1'b1;
            r_sel_sync  <= 1'b1;
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_data_meta <= 4'h0;
            r_data_sync <= 4'h0;
        end else begin
            r_sel_meta  <= i_select;
            r_sel_sync  <= r_sel_meta;
            r_sck_meta  <= i_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_data_meta <= i_data;
            r_data_sync <= r_data_meta;
        end
    end

    assign o_select   = r_sel_sync;
    assign o_data     = r_data_sync;
    assign o_sck_rise = r_sck_sync & ~r_sck_prev;
    assign o_sck_fall = ~r_sck_sync & r_sck_prev;

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: answers quad fast-read (0xEB) transactions from a
// synchronous byte memory, oversampling the SPI pins on the system clock.
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int         ADDR_BITS     = 24,
    parameter int         MEM_ADDR_BITS = 20,
    parameter int         DUMMY_CLOCKS  = 4,
    parameter logic [7:0] CMD_QUAD_READ = qspi_pkg::CMD_QUAD_READ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_select,
    input  logic                     spi_clk_in,
    input  logic [3:0]               spi_data_in,
    output logic [3:0]               spi_data_out,
    output logic [3:0]               spi_data_oe,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic                     mem_rd,
    input  logic [7:0]               mem_data,
    output logic                     busy,
    output logic                     cont_mode
);

    localparam logic [7:0] CMD_LAST   = 8'd7;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLOCKS - 1);

    logic       w_sel, w_rise, w_fall;
    logic [3:0] w_data;

    qspi_pin_sync u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_select  (spi_select),
        .i_sck     (spi_clk_in),
        .i_data    (spi_data_in),
        .o_select  (w_sel),
        .o_sck_rise(w_rise),
        .o_sck_fall(w_fall),
        .o_data    (w_data)
    );

    state_t                   r_state;
    logic [7:0]               r_cnt;
    logic [6:0]               r_cmd;
    logic [MEM_ADDR_BITS-1:0] r_addr;
    logic [1:0]               r_mode_hi;
    logic [7:0]               r_byte;
    logic                     r_nib_low;
    logic                     r_rd_d1;
    logic [3:0]               r_data_out, r_oe;
    logic [MEM_ADDR_BITS-1:0] r_mem_addr;
    logic                     r_mem_rd, r_busy, r_cont;

    // NOTE: all state uses non-blocking assignments so every register sees the
    // pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_cmd      <= 7'd0;
            r_addr     <= '0;
            r_mode_hi  <= 2'b00;
            r_byte     <= 8'h00;
            r_nib_low  <= 1'b0;
            r_rd_d1    <= 1'b0;
            r_data_out <= 4'h0;
            r_oe       <= 4'h0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_busy     <= 1'b0;
            r_cont     <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_rd_d1  <= r_mem_rd;
            if (r_rd_d1) r_byte <= mem_data;

            if (w_sel) begin
                r_state <= IDLE;
                r_oe    <= 4'h0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= r_cont ? ADDR : CMD;
                    end
                    CMD: if (w_rise) begin
                        r_cmd <= {r_cmd[5:0], w_data[0]};
                        if (r_cnt == CMD_LAST) begin
                            r_cnt   <= 8'd0;
                            r_state <= ({r_cmd, w_data[0]} == CMD_QUAD_READ) ? ADDR : IGNORE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    ADDR: if (w_rise) begin
                        // Nibbles above the memory width simply shift out the top.
                        r_addr <= {r_addr[MEM_ADDR_BITS-5:0], w_data};
                        if (r_cnt == ADDR_LAST) begin
                            r_cnt   <= 8'd0;
                            r_state <= MODE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    MODE: if (w_rise) begin
                        if (r_cnt == 8'd0) begin
                            r_mode_hi <= w_data[1:0];
                            r_cnt     <= 8'd1;
                        end else begin
                            r_cont     <= (r_mode_hi == MODE_CONT);
                            r_mem_addr <= r_addr;
                            r_mem_rd   <= 1'b1;
                            r_cnt      <= 8'd0;
                            r_state    <= DUMMY;
                        end
                    end
                    DUMMY: if (w_rise) begin
                        if (r_cnt == DUMMY_LAST) begin
                            r_nib_low <= 1'b0;
                            r_state   <= DATA;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    DATA: if (w_fall) begin
                        r_oe <= 4'hF;
                        if (!r_nib_low) begin
                            r_data_out <= r_byte[7:4];
                            r_nib_low  <= 1'b1;
                        end else begin
                            // Fetch the next byte while its predecessor's low nibble is on the pins.
                            r_data_out <= r_byte[3:0];
                            r_nib_low  <= 1'b0;
                            r_mem_addr <= r_mem_addr + 1'b1;
                            r_mem_rd   <= 1'b1;
                        end
                    end
                    IGNORE: r_oe <= 4'h0;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign spi_data_out = r_data_out;
    assign spi_data_oe  = r_oe;
    assign mem_addr     = r_mem_addr;
    assign mem_rd       = r_mem_rd;
    assign busy         = r_busy;
    assign cont_mode    = r_cont;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: table of read transactions plus
// hand-written bad-command, abort and asynchronous-reset sequences.
module tb_qspi_flash_responder;

    localparam int HALF   = 60;
    localparam int DUMMYS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_select = 1'b1;
    logic        spi_clk_in = 1'b0;
    logic [3:0]  spi_data_in = 4'h0;
    logic [3:0]  spi_data_out, spi_data_oe;
    logic [19:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        busy, cont_mode;

    qspi_flash_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_select  (spi_select),
        .spi_clk_in  (spi_clk_in),
        .spi_data_in (spi_data_in),
        .spi_data_out(spi_data_out),
        .spi_data_oe (spi_data_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .busy        (busy),
        .cont_mode   (cont_mode)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<20)-1];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int n_pass = 0, n_total = 0;
    int oe_hits = 0, rd_hits = 0;
    always @(posedge clk) begin
        if (spi_data_oe != 4'h0) oe_hits <= oe_hits + 1;
        if (mem_rd) rd_hits <= rd_hits + 1;
    end

    typedef struct {
        bit          use_cmd;
        logic [23:0] addr;
        logic [7:0]  mode;
        int          n;
        logic [31:0] bytes;
        bit          exp_cont;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Samples the pins late in the low phase, then drives one SCK pulse.
    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        spi_data_in = d;
        #(HALF - 5);
        q  = spi_data_out;
        oe = spi_data_oe;
        #5;
        spi_clk_in = 1'b1;
        #HALF;
        spi_clk_in = 1'b0;
    endtask

    task automatic preamble(input bit use_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                            input logic [7:0] mode, output int oe_seen);
        logic [3:0] q, oe;
        oe_seen = 0;
        spi_select = 1'b0;
        #100;
        if (use_cmd)
            for (int i = 7; i >= 0; i--) begin
                sck_cycle({3'b000, cmd[i]}, q, oe);
                if (oe != 4'h0) oe_seen++;
            end
        for (int i = 5; i >= 0; i--) begin
            sck_cycle(addr[i*4 +: 4], q, oe);
            if (oe != 4'h0) oe_seen++;
        end
        sck_cycle(mode[7:4], q, oe);
        if (oe != 4'h0) oe_seen++;
        sck_cycle(mode[3:0], q, oe);
        if (oe != 4'h0) oe_seen++;
        for (int i = 0; i < DUMMYS; i++) begin
            sck_cycle(4'h0, q, oe);
            if (oe != 4'h0) oe_seen++;
        end
    endtask

    task automatic read_bytes(input string tag, input int n, input logic [31:0] exp);
        logic [3:0] q, oe;
        for (int k = 0; k < 2 * n; k++) begin
            sck_cycle(4'h0, q, oe);
            check($sformatf("%s_nib%0d", tag, k), {28'h0, q}, {28'h0, exp[31 - 4*k -: 4]});
            check($sformatf("%s_oe%0d", tag, k), {28'h0, oe}, 32'hF);
        end
    endtask

    task automatic deselect(input string tag);
        spi_select = 1'b1;
        #100;
        check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_idle_oe"}, {28'h0, spi_data_oe}, 32'h0);
    endtask

    initial begin
        int         oe_seen, oe_before, rd_before;
        logic [3:0] q, oe;

        for (int i = 0; i < (1 << 20); i++) mem[i] = 8'(i * 7);
        mem[20'h00010] = 8'h12; mem[20'h00011] = 8'h34;
        mem[20'h00012] = 8'h56; mem[20'h00013] = 8'h78;
        mem[20'h00020] = 8'hA1; mem[20'h00021] = 8'hB2;
        mem[20'h00040] = 8'h11; mem[20'h00041] = 8'h22;
        mem[20'hFFFFF] = 8'hC3;
        mem[20'h00000] = 8'h9E; mem[20'h00001] = 8'h4D;

        vecs[0] = '{1'b1, 24'h100010, 8'h00, 4, 32'h12345678, 1'b0};
        vecs[1] = '{1'b1, 24'h000040, 8'hA0, 2, 32'h11220000, 1'b1};
        vecs[2] = '{1'b0, 24'h000020, 8'hA0, 2, 32'hA1B20000, 1'b1};
        vecs[3] = '{1'b0, 24'h000020, 8'hFF, 1, 32'hA1000000, 1'b0};
        vecs[4] = '{1'b1, 24'h0FFFFF, 8'h00, 3, 32'hC39E4D00, 1'b0};

        #12;
        check("rst_oe", {28'h0, spi_data_oe}, 32'h0);
        check("rst_out", {28'h0, spi_data_out}, 32'h0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_addr", {12'h0, mem_addr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_cont", {31'h0, cont_mode}, 32'h0);
        #10;
        rst_n = 1'b1;
        #50;

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            preamble(vecs[v].use_cmd, 8'hEB, vecs[v].addr, vecs[v].mode, oe_seen);
            check({tag, "_pre_oe"}, 32'(oe_seen), 32'h0);
            read_bytes(tag, vecs[v].n, vecs[v].bytes);
            check({tag, "_busy"}, {31'h0, busy}, 32'h1);
            check({tag, "_cont"}, {31'h0, cont_mode}, {31'h0, vecs[v].exp_cont});
            deselect(tag);
        end

        oe_before = oe_hits;
        rd_before = rd_hits;
        spi_select = 1'b0;
        #100;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, 8'h03 >> i} & 4'h1, q, oe);
        for (int i = 0; i < 40; i++) sck_cycle(4'hF, q, oe);
        check("badcmd_busy", {31'h0, busy}, 32'h1);
        check("badcmd_oe_cycles", 32'(oe_hits - oe_before), 32'h0);
        check("badcmd_mem_rd", 32'(rd_hits - rd_before), 32'h0);
        deselect("badcmd");

        preamble(1'b1, 8'hEB, 24'h000000, 8'h00, oe_seen);
        #(HALF - 5);
        check("abort_nib0", {28'h0, spi_data_out}, 32'h9);
        check("abort_oe_before", {28'h0, spi_data_oe}, 32'hF);
        spi_select = 1'b1;
        #30;
        check("abort_oe", {28'h0, spi_data_oe}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        #100;
        preamble(1'b1, 8'hEB, 24'h000000, 8'h00, oe_seen);
        read_bytes("reread", 2, 32'h9E4D0000);
        deselect("reread");

        preamble(1'b1, 8'hEB, 24'h000000, 8'hA0, oe_seen);
        read_bytes("prerst", 1, 32'h9E000000);
        #20;
        check("prerst_cont", {31'h0, cont_mode}, 32'h1);
        check("prerst_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_oe", {28'h0, spi_data_oe}, 32'h0);
        check("arst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_cont", {31'h0, cont_mode}, 32'h0);
        spi_select = 1'b1;
        #50;
        rst_n = 1'b1;
        #50;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable QSPI flash responder. It is the far end of the cartridge-ROM QSPI link: it answers quad fast-read (0xEB) transactions from the system's flash controller.
- Read bytes come from a synchronous byte memory, a ROM image in BRAM.
- Used as an FPGA-side flash emulator and as a self-checking bench peer for the controller.
- Runs on the system clock and oversamples the SPI pins; it does not clock on SCK.

Parameters:
- ADDR_BITS, 24, width of the SPI address field.
- MEM_ADDR_BITS, 20, width of the backing-memory address; it is the low bits of the SPI address.
- DUMMY_CLOCKS, 4, SCK cycles between the mode byte and the first data nibble.
- CMD_QUAD_READ, 8'hEB, the only accepted command.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_select  in  1  chip select from the initiator, active low
- spi_clk_in  in  1  SCK from the initiator
- spi_data_in  in  4  SD3..SD0 from the initiator
- spi_data_out  out  4  SD3..SD0 driven to the initiator
- spi_data_oe  out  4  output enables for SD3..SD0, 1 = drive
- mem_addr  out  MEM_ADDR_BITS  backing-memory address
- mem_rd  out  1  single-cycle read strobe
- mem_data  in  8  memory read data, valid exactly 1 clk after mem_rd
- busy  out  1  high while a transaction is in progress (select low)
- cont_mode  out  1  continuous-read mode latched

Behaviour:
- Reset: asynchronous, active-low, defined for all outputs.
  - spi_data_out=0, spi_data_oe=0, mem_rd=0, mem_addr=0, busy=0, cont_mode=0, state=IDLE.
- Input synchronisation:
  - spi_select, spi_clk_in and spi_data_in each pass through a 2-flop synchroniser.
  - SCK rise and fall are detected from the synchronised SCK and its previous value.
  - Requirement: the SCK high and low phases are each at least 3 clk.
- Edge rules:
  - Inputs are sampled on the detected SCK rise.
  - Outputs are updated on the detected SCK fall.
- Select deassert (synchronised select high) has priority over everything, in any state and mid-byte:
  - state → IDLE, spi_data_oe → 0 on the next clk, busy → 0, mem_addr counter discarded.
  - cont_mode is kept.
- Select fall in IDLE: busy=1, bit/nibble counter cleared.
  - Next state is ADDR if cont_mode=1, otherwise CMD.
- CMD: 8 SCK rises, SD0 only, MSB first.
  - After the 8th rise, a byte equal to CMD_QUAD_READ → ADDR.
  - Any other byte → IGNORE. IGNORE keeps oe=0 until select rises.
- ADDR: ADDR_BITS/4 quad rises, MSB nibble first. After the last rise → MODE.
- MODE: 2 quad rises form the mode byte.
  - cont_mode is set to 1 when mode[5:4]==2'b10 (e.g. 0xA0), otherwise 0.
  - The low MEM_ADDR_BITS of the address are loaded into mem_addr, and mem_rd is pulsed for 1 clk.
  - Next state is DUMMY.
- DUMMY: count DUMMY_CLOCKS rises.
  - The prefetched byte is captured into a shift register 1 clk after mem_rd.
  - oe stays 0 in this state.
- DATA transition: on the SCK fall after the last dummy rise:
  - oe=4'hF.
  - spi_data_out = high nibble of the prefetched byte.
- DATA, per byte:
  - Each subsequent fall alternates between the low nibble and the next byte's high nibble.
  - On the fall that outputs the low nibble, mem_addr increments and mem_rd pulses. The next byte is then ready ≥2 clk before the following fall.
- Wrap-around: mem_addr wraps from 2^MEM_ADDR_BITS-1 to 0. Address bits above MEM_ADDR_BITS are ignored.
- Latency: the first data nibble is valid on the first SCK fall after DUMMY_CLOCKS dummy rises. Streaming continues without gaps until select rises.
- A select pulse shorter than one SCK cycle never causes the data lines to be driven.

Decomposition:
- Shared package qspi_pkg:
  - state enum (IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE)
  - CMD_QUAD_READ
  - continuous-mode match bits MODE_CONT=2'b10
- Sub-module qspi_pin_sync: 2-flop synchroniser for select/clk/data, plus the SCK rise/fall pulse generation. It is reused by other bench peers.

Test Plan:
- Read 4 bytes:
  - Stimulus: select low, cmd 0xEB on SD0, addr 0x100010, mode 0x00, 4 dummy clocks, 8 data clocks; memory holds 0x12,0x34,0x56,0x78 at 0x00010.
  - Required: nibbles 1,2,3,4,5,6,7,8 on successive falls; cont_mode=0.
- Continuous mode:
  - Stimulus: first transaction with mode 0xA0; then select high, select low, address 0x000020 with no command.
  - Required: data from 0x00020 is returned; cont_mode stays 1.
  - Stimulus: next transaction with mode 0xFF.
  - Required: cont_mode clears; the following transaction expects a command again.
- Bad command:
  - Stimulus: cmd 0x03 followed by 40 clocks.
  - Required: spi_data_oe stays 0 throughout; mem_rd is never asserted.
- Abort mid-byte:
  - Stimulus: select rises after the first data nibble.
  - Required: oe=0 within 3 clk; busy=0; a fresh 0xEB read at 0x000000 returns correct data.
- Wrap:
  - Stimulus: read 3 bytes from address 0x0FFFFF with MEM_ADDR_BITS=20.
  - Required: bytes come from mem[0xFFFFF], mem[0x00000], mem[0x00001].
- Reset:
  - Stimulus: assert rst_n low mid-DATA, asynchronously.
  - Required: oe, mem_rd, busy and cont_mode all go 0 immediately, without waiting for a clk edge.
